// File: rtl/prbs31_bert_monitor_if.sv
// Bus bundle for the PRBS31 BER monitor.
// The master side (stream source / register reader) drives the serial
// stream, the counter controls and the read select. The slave side (the
// monitor) returns the registered read byte and the lock/error indications.
//   rx_bit, rx_valid : serial test stream and its qualifier
//   clr, snap        : clear live counters / copy live counters to shadows
//   rd_sel, rd_data  : byte select and registered read data
//   locked           : monitor is locked to the stream
//   err_pulse        : one pulse per mismatched bit while locked
//   sync_loss        : one pulse when lock is dropped
interface prbs31_bert_monitor_if;
  logic       rx_bit;
  logic       rx_valid;
  logic       clr;
  logic       snap;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       locked;
  logic       err_pulse;
  logic       sync_loss;

  modport master (
    output rx_bit, rx_valid, clr, snap, rd_sel,
    input  rd_data, locked, err_pulse, sync_loss
  );

  modport slave (
    input  rx_bit, rx_valid, clr, snap, rd_sel,
    output rd_data, locked, err_pulse, sync_loss
  );
endinterface

// File: rtl/prbs31_bert_monitor.sv
// Receive-side PRBS31 (x^31 + x^28 + 1) bit-error-rate monitor.
// A local predictor is seeded from 31 received bits, verified against
// LOCK_CNT further bits and then free-runs while bits and errors are
// counted. Too many errors inside one WINDOW of bits drops lock and the
// monitor reseeds. Live counters are copied to shadow registers on snap
// and read back one byte at a time.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active high
//   bus   : prbs31_bert_monitor_if.slave
//           rd_sel 0-3 -> bit_cnt bytes (LSB first), 4-6 -> err_cnt bytes,
//           7 -> status {5'b0, sat_flag, state[1:0]}
module prbs31_bert_monitor #(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 1024,
  parameter int ERR_THRESH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  prbs31_bert_monitor_if.slave bus
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);

  localparam logic [MATCH_W-1:0] LOCK_VAL   = MATCH_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  THRESH_VAL = WERR_W'(ERR_THRESH);
  localparam logic [4:0]         FILL_LAST  = 5'd30;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [30:0]         pred, pred_nxt;
  logic [4:0]          fill, fill_nxt;
  logic [MATCH_W-1:0]  match, match_nxt, match_inc;
  logic [WIN_W-1:0]    win, win_nxt;
  logic [WERR_W-1:0]   win_err, win_err_nxt, win_err_sum;
  logic                err_pulse_q, err_pulse_nxt;
  logic                sync_loss_q, sync_loss_nxt;
  logic                count_bit, count_err;

  logic [31:0]         bit_cnt, bit_shadow;
  logic [23:0]         err_cnt, err_shadow;
  logic                sat_flag;
  logic [7:0]          rd_data_q;

  logic                exp_bit, mis;
  logic [30:0]         pred_load, pred_run;

  // Predictor taps: the next PRBS31 bit is the XOR of the bits 31 and 28
  // positions back, i.e. pred[30] and pred[27].
  assign exp_bit     = pred[27] ^ pred[30];
  assign mis         = bus.rx_bit ^ exp_bit;
  assign pred_load   = {pred[29:0], bus.rx_bit};
  assign pred_run    = {pred[29:0], exp_bit};
  assign match_inc   = match + MATCH_W'(1);
  assign win_err_sum = win_err + WERR_W'(mis);

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decisions. Nothing moves without rx_valid,
  // except that an illegal state encoding falls straight back to HUNT.
  always_comb begin
    state_nxt     = state;
    pred_nxt      = pred;
    fill_nxt      = fill;
    match_nxt     = match;
    win_nxt       = win;
    win_err_nxt   = win_err;
    err_pulse_nxt = 1'b0;
    sync_loss_nxt = 1'b0;
    count_bit     = 1'b0;
    count_err     = 1'b0;

    case (state)
      HUNT: begin
        if (bus.rx_valid) begin
          pred_nxt = pred_load;
          if (fill == FILL_LAST) begin
            fill_nxt = '0;
            // An all-zero seed would predict zeros forever, so keep hunting.
            if (pred_load != '0) begin
              state_nxt = VERIFY;
              match_nxt = '0;
            end
          end else begin
            fill_nxt = fill + 5'd1;
          end
        end
      end

      VERIFY: begin
        if (bus.rx_valid) begin
          pred_nxt = pred_run;
          if (mis) begin
            match_nxt = '0;
            fill_nxt  = '0;
            state_nxt = HUNT;
          end else begin
            match_nxt = match_inc;
            if (match_inc == LOCK_VAL) begin
              state_nxt = LOCKED;
            end
          end
        end
      end

      LOCKED: begin
        if (bus.rx_valid) begin
          pred_nxt      = pred_run;
          count_bit     = 1'b1;
          count_err     = mis;
          err_pulse_nxt = mis;
          // The error threshold wins over a window close on the same bit.
          if (win_err_sum == THRESH_VAL) begin
            state_nxt     = HUNT;
            fill_nxt      = '0;
            match_nxt     = '0;
            win_nxt       = '0;
            win_err_nxt   = '0;
            sync_loss_nxt = 1'b1;
          end else if (win == WIN_LAST) begin
            win_nxt     = '0;
            win_err_nxt = '0;
          end else begin
            win_nxt     = win + WIN_W'(1);
            win_err_nxt = win_err_sum;
          end
        end
      end

      default: begin
        state_nxt   = HUNT;
        fill_nxt    = '0;
        match_nxt   = '0;
        win_nxt     = '0;
        win_err_nxt = '0;
      end
    endcase
  end

  // Predictor, fill/match/window bookkeeping and the pulse outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pred        <= '0;
      fill        <= '0;
      match       <= '0;
      win         <= '0;
      win_err     <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      pred        <= pred_nxt;
      fill        <= fill_nxt;
      match       <= match_nxt;
      win         <= win_nxt;
      win_err     <= win_err_nxt;
      err_pulse_q <= err_pulse_nxt;
      sync_loss_q <= sync_loss_nxt;
    end
  end

  // Live counters saturate at all-ones; sat_flag latches when either one
  // reaches its maximum. clr overrides a bit counted on the same edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_cnt  <= '0;
      err_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (bus.clr) begin
      bit_cnt  <= '0;
      err_cnt  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (count_bit && (bit_cnt != '1)) begin
        bit_cnt <= bit_cnt + 32'd1;
      end
      if (count_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 24'd1;
      end
      if ((count_bit && (&bit_cnt[31:1])) || (count_err && (&err_cnt[23:1]))) begin
        sat_flag <= 1'b1;
      end
    end
  end

  // Shadows take the counter values as they stand before this edge, so a
  // simultaneous clr still leaves the old totals readable.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_shadow <= '0;
      err_shadow <= '0;
    end else if (bus.snap) begin
      bit_shadow <= bit_cnt;
      err_shadow <= err_cnt;
    end
  end

  // Registered byte read; the status byte reflects live state, not shadows.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_data_q <= '0;
    end else begin
      case (bus.rd_sel)
        3'd0:    rd_data_q <= bit_shadow[7:0];
        3'd1:    rd_data_q <= bit_shadow[15:8];
        3'd2:    rd_data_q <= bit_shadow[23:16];
        3'd3:    rd_data_q <= bit_shadow[31:24];
        3'd4:    rd_data_q <= err_shadow[7:0];
        3'd5:    rd_data_q <= err_shadow[15:8];
        3'd6:    rd_data_q <= err_shadow[23:16];
        default: rd_data_q <= {5'b0, sat_flag, state};
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_loss = sync_loss_q;

endmodule
